// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator CPU: fetch FSM states,
// the instruction-length bit and the default reset address.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH_HI,
        ST_FETCH_LO,
        ST_VALID
    } fetch_state_t;

    // Opcode bit that marks a two-byte (one-operand) instruction; the decoder
    // sees this as inst[15].
    localparam int OPC_LONG_BIT = 7;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch unit: reads opcode/operand bytes over a byte-wide req/ack
// port and hands assembled 16-bit instructions to the core via valid/ready.
//
// state    | meaning
// ---------+------------------------------------------------------------
// BOOT     | one idle cycle after reset
// FETCH_HI | requesting opcode byte at pc
// FETCH_LO | requesting operand byte at pc+1
// VALID    | instruction presented, waiting for inst_ready
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_load,
    input  logic [15:0] pc_target,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    output logic [15:0] inst_next_pc
);

    fetch_state_t state, state_nxt;

    logic [15:0] pc, pc_nxt;
    logic [15:0] pc_plus1;
    logic [15:0] inst_nxt, inst_pc_nxt, inst_next_pc_nxt;
    logic        redirect_pend, redirect_pend_nxt;
    logic [15:0] redirect_tgt, redirect_tgt_nxt;
    logic [15:0] restart_pc;

    assign pc_plus1 = pc + 16'd1;

    // A fresh pc_load on the acking cycle overrides an older latched target.
    assign restart_pc = pc_load ? pc_target : redirect_tgt;

    assign mem_req    = (state == ST_FETCH_HI) || (state == ST_FETCH_LO);
    assign mem_addr   = (state == ST_FETCH_LO) ? pc_plus1 : pc;
    assign inst_valid = (state == ST_VALID);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_BOOT;
            pc            <= RESET_PC;
            inst          <= 16'h0000;
            inst_pc       <= RESET_PC;
            inst_next_pc  <= RESET_PC;
            redirect_pend <= 1'b0;
            redirect_tgt  <= RESET_PC;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            inst          <= inst_nxt;
            inst_pc       <= inst_pc_nxt;
            inst_next_pc  <= inst_next_pc_nxt;
            redirect_pend <= redirect_pend_nxt;
            redirect_tgt  <= redirect_tgt_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        pc_nxt            = pc;
        inst_nxt          = inst;
        inst_pc_nxt       = inst_pc;
        inst_next_pc_nxt  = inst_next_pc;
        redirect_pend_nxt = redirect_pend;
        redirect_tgt_nxt  = redirect_tgt;

        case (state)
            ST_BOOT: begin
                state_nxt = ST_FETCH_HI;
                if (pc_load) begin
                    pc_nxt = pc_target;
                end
            end

            ST_FETCH_HI: begin
                if (mem_ack) begin
                    if (pc_load || redirect_pend) begin
                        pc_nxt            = restart_pc;
                        redirect_pend_nxt = 1'b0;
                        state_nxt         = ST_FETCH_HI;
                    end else begin
                        inst_nxt[15:8] = mem_rdata;
                        inst_pc_nxt    = pc;
                        if (mem_rdata[OPC_LONG_BIT]) begin
                            state_nxt = ST_FETCH_LO;
                        end else begin
                            inst_nxt[7:0]    = 8'h00;
                            inst_next_pc_nxt = pc_plus1;
                            state_nxt        = ST_VALID;
                        end
                    end
                end else if (pc_load) begin
                    redirect_pend_nxt = 1'b1;
                    redirect_tgt_nxt  = pc_target;
                end
            end

            ST_FETCH_LO: begin
                if (mem_ack) begin
                    if (pc_load || redirect_pend) begin
                        pc_nxt            = restart_pc;
                        redirect_pend_nxt = 1'b0;
                        state_nxt         = ST_FETCH_HI;
                    end else begin
                        inst_nxt[7:0]    = mem_rdata;
                        inst_next_pc_nxt = pc + 16'd2;
                        state_nxt        = ST_VALID;
                    end
                end else if (pc_load) begin
                    redirect_pend_nxt = 1'b1;
                    redirect_tgt_nxt  = pc_target;
                end
            end

            ST_VALID: begin
                if (pc_load) begin
                    pc_nxt    = pc_target;
                    state_nxt = ST_FETCH_HI;
                end else if (inst_ready) begin
                    pc_nxt    = inst_next_pc;
                    state_nxt = ST_FETCH_HI;
                end
            end

            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a random phase, with every
// delivered instruction compared against a program-order model of memory.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic [15:0] inst_next_pc;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_load      (pc_load),
        .pc_target    (pc_target),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_next_pc (inst_next_pc)
    );

    int errors = 0;
    int checks = 0;
    int delivered = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] model_pc;
    int          ack_delay;
    int          waitcnt;
    logic        drv_load;
    logic        drv_ready;
    logic [15:0] drv_tgt;
    logic        prev_pending;
    logic [15:0] prev_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: called and returning at posedge+1.
    task automatic cycle();
        logic        req_now, ack_now, valid_s;
        logic [15:0] addr_now, a1, exp_inst, exp_next;
        logic [7:0]  op;
        pc_load    = drv_load;
        pc_target  = drv_tgt;
        inst_ready = drv_ready;
        if (prev_pending) begin
            check("req_hold", mem_req, 1);
            check("addr_hold", mem_addr, prev_addr);
        end
        req_now  = mem_req;
        addr_now = mem_addr;
        if (mem_req && waitcnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
        end
        ack_now = mem_ack;
        exp_next = model_pc;
        @(negedge clk);
        valid_s = inst_valid;
        if (inst_valid) begin
            op = mem[model_pc];
            a1 = model_pc + 16'd1;
            if (op[7]) begin
                exp_inst = {op, mem[a1]};
                exp_next = model_pc + 16'd2;
            end else begin
                exp_inst = {op, 8'h00};
                exp_next = a1;
            end
            check("model_inst", inst, exp_inst);
            check("model_inst_pc", inst_pc, model_pc);
            check("model_next_pc", inst_next_pc, exp_next);
        end
        @(posedge clk);
        if (drv_load) begin
            model_pc = drv_tgt;
        end else if (valid_s && drv_ready) begin
            model_pc = exp_next;
            delivered++;
        end
        if (req_now && !ack_now) waitcnt++;
        else waitcnt = 0;
        prev_pending = req_now && !ack_now;
        prev_addr    = addr_now;
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 30; i++) begin
            if (inst_valid) break;
            cycle();
        end
        check(tag, inst_valid, 1);
    endtask

    initial begin
        rst_n = 1'b0; pc_load = 1'b0; pc_target = 16'h0; mem_ack = 1'b0;
        mem_rdata = 8'h0; inst_ready = 1'b0;
        drv_load = 1'b0; drv_ready = 1'b0; drv_tgt = 16'h0;
        ack_delay = 0; waitcnt = 0; prev_pending = 1'b0; prev_addr = 16'h0;
        model_pc = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0000] = 8'h01;
        mem[16'h0010] = 8'h80; mem[16'h0011] = 8'h2A;
        mem[16'h0012] = 8'h81; mem[16'h0013] = 8'h77;
        mem[16'h0400] = 8'h05;
        mem[16'h0200] = 8'h10;
        mem[16'hFFFF] = 8'h88;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst", inst, 16'h0000);
        check("rst_inst_pc", inst_pc, 16'h0000);
        check("rst_inst_next_pc", inst_next_pc, 16'h0000);
        rst_n = 1'b1;

        // Zero-arg fetch with same-cycle ack
        cycle();
        check("t1_req_cycle1", mem_req, 1);
        check("t1_addr_cycle1", mem_addr, 16'h0000);
        cycle();
        check("t1_valid_cycle2", inst_valid, 1);
        check("t1_inst", inst, 16'h0100);
        check("t1_next_pc", inst_next_pc, 16'h0001);

        // Redirect to 0x10, one-arg fetch with 2-cycle ack delay
        drv_load = 1'b1; drv_tgt = 16'h0010; ack_delay = 2;
        cycle();
        drv_load = 1'b0;
        check("t2_valid_dropped", inst_valid, 0);
        check("t2_addr_hi", mem_addr, 16'h0010);
        wait_valid("t2_valid_timeout");
        check("t2_inst", inst, 16'h802A);
        check("t2_next_pc", inst_next_pc, 16'h0012);

        // Stall in VALID
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t3_stall_valid", inst_valid, 1);
            check("t3_stall_no_req", mem_req, 0);
            check("t3_stall_inst", inst, 16'h802A);
        end
        ack_delay = 0; drv_ready = 1'b1;
        cycle();
        drv_ready = 1'b0;
        check("t3_next_req", mem_req, 1);
        check("t3_next_addr", mem_addr, 16'h0012);

        // Redirect during an un-acked operand fetch
        cycle();
        check("t4_in_lo_addr", mem_addr, 16'h0013);
        ack_delay = 3; drv_load = 1'b1; drv_tgt = 16'h0400;
        cycle();
        drv_load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t4_no_valid", inst_valid, 0);
            if (mem_addr == 16'h0400) break;
            cycle();
        end
        check("t4_restart_addr", mem_addr, 16'h0400);
        check("t4_restart_req", mem_req, 1);
        ack_delay = 0;
        wait_valid("t4_valid_timeout");
        check("t4_inst", inst, 16'h0500);

        // Redirect coinciding with acceptance
        drv_load = 1'b1; drv_tgt = 16'h0200; drv_ready = 1'b1;
        cycle();
        drv_load = 1'b0; drv_ready = 1'b0;
        check("t5_addr", mem_addr, 16'h0200);
        check("t5_req", mem_req, 1);
        wait_valid("t5_valid_timeout");
        check("t5_inst_pc", inst_pc, 16'h0200);

        // Wrap at 0xFFFF
        mem[16'h0000] = 8'h05;
        drv_load = 1'b1; drv_tgt = 16'hFFFF;
        cycle();
        drv_load = 1'b0;
        check("t6_addr_hi", mem_addr, 16'hFFFF);
        cycle();
        check("t6_addr_lo_wrap", mem_addr, 16'h0000);
        wait_valid("t6_valid_timeout");
        check("t6_inst", inst, 16'h8805);
        check("t6_next_pc", inst_next_pc, 16'h0001);

        // Reset during FETCH_LO
        drv_load = 1'b1; drv_tgt = 16'hFFFF;
        cycle();
        drv_load = 1'b0;
        cycle();
        check("t7_in_lo", mem_addr, 16'h0000);
        ack_delay = 10;
        cycle();
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_req", mem_req, 0);
        check("t7_rst_valid", inst_valid, 0);
        check("t7_rst_inst", inst, 16'h0000);
        mem_ack = 1'b0; pc_load = 1'b0; inst_ready = 1'b0;
        model_pc = 16'h0000; waitcnt = 0; prev_pending = 1'b0; ack_delay = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();
        check("t7_restart_addr", mem_addr, 16'h0000);
        check("t7_restart_req", mem_req, 1);
        wait_valid("t7_valid_timeout");
        check("t7_inst", inst, 16'h0500);

        // Random traffic against the program-order model
        delivered = 0;
        for (int i = 0; i < 600; i++) begin
            ack_delay = $urandom_range(0, 2);
            drv_ready = 1'($urandom_range(0, 1));
            drv_load  = ($urandom_range(0, 11) == 0);
            drv_tgt   = 16'($urandom);
            cycle();
        end
        drv_load = 1'b0;
        check("rand_progress", (delivered > 20), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
